// File: rtl/stage_instruction_decode.sv
// RV32I decode stage: 32x32 register file with write-through bypass, control and
// immediate decode, and the DE/EX pipeline register feeding execute.
module stage_instruction_decode #(
  parameter int RESET_CLEARS_RF = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] de_instr,
  input  logic [31:0] de_pc,
  input  logic [31:0] de_pc_plus4,
  input  logic        ex_stall,
  input  logic        ex_clear,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic [4:0]  de_rs1,
  output logic [4:0]  de_rs2,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_pc_plus4,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic [1:0]  ex_result_src,
  output logic        ex_mem_write,
  output logic        ex_mem_read,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_jalr,
  output logic [3:0]  ex_alu_ctrl,
  output logic [1:0]  ex_alu_src_a,
  output logic        ex_alu_src_b,
  output logic [2:0]  ex_funct3,
  output logic        ex_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        mem_read;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [3:0]  alu_ctrl;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [2:0]  funct3;
    logic        illegal;
  } de_ex_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? 4'd1 : 4'd0;
      3'b001:  alu_op = 4'd7;
      3'b010:  alu_op = 4'd5;
      3'b011:  alu_op = 4'd6;
      3'b100:  alu_op = 4'd4;
      3'b101:  alu_op = alt ? 4'd9 : 4'd8;
      3'b110:  alu_op = 4'd3;
      3'b111:  alu_op = 4'd2;
      default: alu_op = 4'd0;
    endcase
  endfunction

  logic [31:0] rf_q [32];
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s;
  logic [31:0] rd1_s, rd2_s;
  logic        illegal_s;
  de_ex_t      de_ex_d, ex_q;

  assign opcode_s = de_instr[6:0];
  assign funct3_s = de_instr[14:12];
  assign funct7_s = de_instr[31:25];
  assign de_rs1   = de_instr[19:15];
  assign de_rs2   = de_instr[24:20];

  assign imm_i_s = {{20{de_instr[31]}}, de_instr[31:20]};
  assign imm_s_s = {{20{de_instr[31]}}, de_instr[31:25], de_instr[11:7]};
  assign imm_b_s = {{20{de_instr[31]}}, de_instr[7], de_instr[30:25], de_instr[11:8], 1'b0};
  assign imm_j_s = {{12{de_instr[31]}}, de_instr[19:12], de_instr[20], de_instr[30:21], 1'b0};
  assign imm_u_s = {de_instr[31:12], 12'h000};

  // A same-cycle writeback to the read index wins over the stored value.
  assign rd1_s = (de_rs1 == 5'd0) ? 32'd0 :
                 (wb_reg_write && (wb_rd == de_rs1)) ? wb_result : rf_q[de_rs1];
  assign rd2_s = (de_rs2 == 5'd0) ? 32'd0 :
                 (wb_reg_write && (wb_rd == de_rs2)) ? wb_result : rf_q[de_rs2];

  // Register file writes; reset drops any writeback presented alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (RESET_CLEARS_RF != 0) begin
        for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end
    end else if (wb_reg_write && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_result;
    end
  end

  always_comb begin
    illegal_s = 1'b0;
    case (opcode_s)
      OP_LUI, OP_AUIPC, OP_JAL: illegal_s = 1'b0;
      OP_JALR:   illegal_s = (funct3_s != 3'b000);
      OP_BRANCH: illegal_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
      OP_LOAD:   illegal_s = (funct3_s == 3'b011) || (funct3_s[2:1] == 2'b11);
      OP_STORE:  illegal_s = funct3_s[2] || (funct3_s == 3'b011);
      OP_IMM:    illegal_s = ((funct3_s == 3'b001) && (funct7_s != 7'h00)) ||
                             ((funct3_s == 3'b101) && (funct7_s != 7'h00) && (funct7_s != 7'h20));
      OP_REG:    illegal_s = !((funct7_s == 7'h00) ||
                               ((funct7_s == 7'h20) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
      // The all-zero flush bubble is a legal NOP.
      default:   illegal_s = (de_instr != 32'd0);
    endcase
  end

  always_comb begin
    de_ex_d          = '0;
    de_ex_d.rd1      = rd1_s;
    de_ex_d.rd2      = rd2_s;
    de_ex_d.pc       = de_pc;
    de_ex_d.pc_plus4 = de_pc_plus4;
    de_ex_d.rs1      = de_rs1;
    de_ex_d.rs2      = de_rs2;
    de_ex_d.rd       = de_instr[11:7];
    if (illegal_s) begin
      de_ex_d.illegal = 1'b1;
    end else begin
      de_ex_d.funct3 = funct3_s;
      case (opcode_s)
        OP_LUI: begin
          de_ex_d.reg_write = 1'b1; de_ex_d.alu_src_a = 2'b10; de_ex_d.alu_src_b = 1'b1;
          de_ex_d.imm = imm_u_s;
        end
        OP_AUIPC: begin
          de_ex_d.reg_write = 1'b1; de_ex_d.alu_src_a = 2'b01; de_ex_d.alu_src_b = 1'b1;
          de_ex_d.imm = imm_u_s;
        end
        OP_JAL: begin
          de_ex_d.reg_write = 1'b1; de_ex_d.result_src = 2'b10; de_ex_d.jump = 1'b1;
          de_ex_d.alu_src_a = 2'b01; de_ex_d.alu_src_b = 1'b1; de_ex_d.imm = imm_j_s;
        end
        OP_JALR: begin
          de_ex_d.reg_write = 1'b1; de_ex_d.result_src = 2'b10; de_ex_d.jump = 1'b1;
          de_ex_d.jalr = 1'b1; de_ex_d.alu_src_b = 1'b1; de_ex_d.imm = imm_i_s;
        end
        OP_BRANCH: begin
          de_ex_d.branch = 1'b1; de_ex_d.alu_ctrl = 4'd1; de_ex_d.imm = imm_b_s;
        end
        OP_LOAD: begin
          de_ex_d.reg_write = 1'b1; de_ex_d.result_src = 2'b01; de_ex_d.mem_read = 1'b1;
          de_ex_d.alu_src_b = 1'b1; de_ex_d.imm = imm_i_s;
        end
        OP_STORE: begin
          de_ex_d.mem_write = 1'b1; de_ex_d.alu_src_b = 1'b1; de_ex_d.imm = imm_s_s;
        end
        OP_IMM: begin
          de_ex_d.reg_write = 1'b1; de_ex_d.alu_src_b = 1'b1; de_ex_d.imm = imm_i_s;
          de_ex_d.alu_ctrl  = alu_op(funct3_s, de_instr[30] && (funct3_s == 3'b101));
        end
        OP_REG: begin
          de_ex_d.reg_write = 1'b1;
          de_ex_d.alu_ctrl  = alu_op(funct3_s, de_instr[30]);
        end
        default: de_ex_d.funct3 = 3'b000;
      endcase
    end
  end

  // DE/EX register: reset, then bubble, then hold, then load.
  always_ff @(posedge clk) begin
    if (reset || ex_clear) begin
      ex_q <= '0;
    end else if (!ex_stall) begin
      ex_q <= de_ex_d;
    end
  end

  assign ex_rd1        = ex_q.rd1;
  assign ex_rd2        = ex_q.rd2;
  assign ex_imm        = ex_q.imm;
  assign ex_pc         = ex_q.pc;
  assign ex_pc_plus4   = ex_q.pc_plus4;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_result_src = ex_q.result_src;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign ex_jalr       = ex_q.jalr;
  assign ex_alu_ctrl   = ex_q.alu_ctrl;
  assign ex_alu_src_a  = ex_q.alu_src_a;
  assign ex_alu_src_b  = ex_q.alu_src_b;
  assign ex_funct3     = ex_q.funct3;
  assign ex_illegal    = ex_q.illegal;

endmodule
